// File: rtl/hex_pkg.sv
// Shared constants and segment encoding for the 8-digit hex display.
// Segments are active-low: bit0=a ... bit6=g.
package hex_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [7:0] SEL_OFF    = 8'hFF;

  // Active-low seven-segment pattern for one hex nibble.
  function automatic logic [6:0] seg_of(input logic [3:0] dig);
    logic [6:0] s;
    s = SEG_OFF;
    case (dig)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_digits_scan_seg_decoder.sv
// Combinational nibble to active-low segment decoder.
// Also reused by the bus controller for readback.
module hex_seg_decoder
  import hex_pkg::*;
(
  input  logic [3:0] dig,
  output logic [6:0] seg
);

  assign seg = seg_of(dig);

endmodule

// File: rtl/hex_digits_scan.sv
// Time-multiplexed scan driver for an 8-digit common-anode display.
// Each slot starts with a blanking gap, then shows the sampled digit.
module hex_digits_scan
  import hex_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] digits_i,
  input  logic [7:0]  bitmask_i,
  output logic [6:0]  hex_led,
  output logic [7:0]  hex_sel,
  output logic        frame_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    dig_q;
  logic          en_q;

  logic          slot_start;
  logic          slot_end;
  logic [3:0]    cur_dig;
  logic          cur_en;
  logic          blank;
  logic          lit;
  logic [6:0]    seg;
  logic [7:0]    sel_lit;

  assign slot_start = (cnt == '0);
  assign slot_end   = (cnt == LAST);

  // On the sampling edge the fresh nibble is used directly, so a
  // zero-length blanking gap still shows the right digit at cnt 0.
  assign cur_dig = slot_start ? digits_i[{idx, 2'b00} +: 4] : dig_q;
  assign cur_en  = slot_start ? bitmask_i[idx] : en_q;

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
      assign blank = (cnt < BLANK);
    end
  endgenerate

  assign lit     = cur_en && !blank;
  assign sel_lit = ~(8'd1 << idx);

  hex_seg_decoder u_dec (
    .dig (cur_dig),
    .seg (seg)
  );

  // Slot counter and digit index; index advances on slot wrap.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Hold the digit and its enable for the whole slot to avoid tearing.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dig_q <= '0;
      en_q  <= 1'b0;
    end else if (slot_start) begin
      dig_q <= digits_i[{idx, 2'b00} +: 4];
      en_q  <= bitmask_i[idx];
    end
  end

  // Registered drive of anodes, segments and the frame marker.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hex_sel <= SEL_OFF;
      hex_led <= SEG_OFF;
      frame_o <= 1'b0;
    end else begin
      hex_sel <= lit ? sel_lit : SEL_OFF;
      hex_led <= lit ? seg : SEG_OFF;
      frame_o <= slot_end && (idx == 3'd7);
    end
  end

endmodule

// File: tb/tb_hex_digits_scan.sv
// Scoreboard bench for hex_digits_scan: a time-based model predicts
// each cycle's outputs for two parameter sets.
module tb_hex_digits_scan;

  typedef struct packed {
    logic [7:0] sel;
    logic [6:0] led;
    logic       frame;
  } obs_t;

  localparam obs_t OFF = '{sel: 8'hFF, led: 7'h7F, frame: 1'b0};

  logic        clk;
  logic        rstn;
  logic [31:0] digits;
  logic [7:0]  mask;
  logic [7:0]  sel0, sel1;
  logic [6:0]  led0, led1;
  logic        fr0, fr1;

  int checks;
  int errors;
  int n0, n1;
  logic [3:0] sd0, sd1;
  logic       se0, se1;
  obs_t q0[$];
  obs_t q1[$];

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_digits_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut0 (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .digits_i  (digits),
    .bitmask_i (mask),
    .hex_led   (led0),
    .hex_sel   (sel0),
    .frame_o   (fr0)
  );

  hex_digits_scan #(.SCAN_DIV(2), .BLANK_CYCLES(0)) dut1 (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .digits_i  (digits),
    .bitmask_i (mask),
    .hex_led   (led1),
    .hex_sel   (sel1),
    .frame_o   (fr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output expected after edge n since reset release.
  function automatic obs_t expect_obs(input int sd, input int b,
                                      input int n, input logic [3:0] d,
                                      input logic en);
    obs_t o;
    int c;
    int k;
    c = (n - 1) % sd;
    k = ((n - 1) / sd) % 8;
    o = OFF;
    o.frame = ((n % (8 * sd)) == 0);
    if (c >= b && en) begin
      o.sel = ~(8'd1 << k);
      o.led = seg_ref[d];
    end
    return o;
  endfunction

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got sel=%h led=%h fr=%b expected sel=%h led=%h fr=%b t=%0t",
               name, act.sel, act.led, act.frame,
               exp.sel, exp.led, exp.frame, $time);
    end
  endtask

  task automatic onehot(input string name, input logic [7:0] s);
    checks++;
    if ($countones(~s) > 1) begin
      errors++;
      $display("FAIL %s got sel=%h expected at most one low bit", name, s);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Reference model for SCAN_DIV=8, BLANK_CYCLES=2.
  initial forever begin
    @(posedge clk);
    if (!rstn) begin
      n0 = 0;
      q0.push_back(OFF);
    end else begin
      n0++;
      if ((n0 - 1) % 8 == 0) begin
        sd0 = digits[4 * (((n0 - 1) / 8) % 8) +: 4];
        se0 = mask[((n0 - 1) / 8) % 8];
      end
      q0.push_back(expect_obs(8, 2, n0, sd0, se0));
    end
  end

  // Reference model for SCAN_DIV=2, BLANK_CYCLES=0.
  initial forever begin
    @(posedge clk);
    if (!rstn) begin
      n1 = 0;
      q1.push_back(OFF);
    end else begin
      n1++;
      if ((n1 - 1) % 2 == 0) begin
        sd1 = digits[4 * (((n1 - 1) / 2) % 8) +: 4];
        se1 = mask[((n1 - 1) / 2) % 8];
      end
      q1.push_back(expect_obs(2, 0, n1, sd1, se1));
    end
  end

  // Monitor: compare observed outputs mid-cycle.
  initial forever begin
    obs_t e;
    @(negedge clk);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("scan_d8b2", {sel0, led0, fr0}, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("scan_d2b0", {sel1, led1, fr1}, e);
    end
    onehot("onehot_d8b2", sel0);
    onehot("onehot_d2b0", sel1);
  end

  initial begin
    checks = 0;
    errors = 0;
    n0 = 0;
    n1 = 0;
    sd0 = '0;
    sd1 = '0;
    se0 = 1'b0;
    se1 = 1'b0;
    rstn = 1'b0;
    digits = 32'h7654_3210;
    mask = 8'hFF;

    // Bring-up and two full frames.
    cycles(3);
    rstn = 1'b1;
    cycles(128);

    // Masked digits.
    mask = 8'b1010_0101;
    cycles(128);

    // Mid-slot write to digit 0 at cnt 4 of slot 0.
    for (int i = 0; i < 200 && (n0 % 64) != 4; i++) cycles(1);
    checks++;
    if ((n0 % 64) != 4) begin
      errors++;
      $display("FAIL align_slot0 got n=%0d expected n mod 64 = 4", n0);
    end
    digits[3:0] = 4'hF;
    cycles(128);

    // Random digits and masks changing at random times.
    repeat (20) begin
      digits = $urandom;
      mask = 8'($urandom);
      cycles(int'($urandom_range(1, 40)));
    end

    // Asynchronous reset while a digit is lit.
    mask = 8'hFF;
    cycles(64);
    for (int i = 0; i < 20 && (n0 % 8) != 5; i++) cycles(1);
    rstn = 1'b0;
    #1;
    cmp("async_rst_d8b2", {sel0, led0, fr0}, OFF);
    cmp("async_rst_d2b0", {sel1, led1, fr1}, OFF);
    cycles(3);
    rstn = 1'b1;
    cycles(80);

    // Sweep all nibbles on digit 3.
    digits = 32'h7654_3210;
    for (int v = 0; v < 16; v++) begin
      digits[15:12] = 4'(v);
      cycles(64);
    end

    cycles(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
